// File: rtl/decode_posit_pkg.sv
// Shared sizing helpers and eposit flag positions for the pipelined posit decoder.
// eposit layout, MSB first: {inf, zero, sign, regime[RW-1:0], expfrac[FW-1:0]}.
package decode_posit_pkg;

  localparam int INF_FROM_MSB  = 0;
  localparam int ZERO_FROM_MSB = 1;
  localparam int SIGN_FROM_MSB = 2;

  function automatic int calc_rw(input int n);
    return $clog2(2 * n - 2);
  endfunction

  function automatic int calc_fw(input int n);
    return n - 3;
  endfunction

  function automatic int calc_ew(input int n);
    return 3 + calc_rw(n) + calc_fw(n);
  endfunction

endpackage

// File: rtl/decode_posit_lane.sv
// Combinational per-lane posit decode: run-length one-hot (stage-1 side) and
// eposit field extraction from a registered posit plus its one-hot (stage-2 side).
module decode_posit_lane
  import decode_posit_pkg::*;
#(
  parameter  int N  = 8,
  localparam int RW = calc_rw(N),
  localparam int FW = calc_fw(N),
  localparam int EW = calc_ew(N)
) (
  input  logic [N-1:0]  posit_s1,
  output logic [N-2:0]  run_oh_s1,
  input  logic [N-1:0]  posit_s2,
  input  logic [N-2:0]  run_oh_s2,
  output logic [EW-1:0] eposit_s2
);

  logic [N-1:0]  ext;
  logic          found;
  logic [RW-1:0] run_m;
  logic [RW-1:0] sh_amt;
  logic [RW-1:0] regime;
  logic [N-1:0]  shifted;
  logic          sign;
  logic          body_zero;

  // A sentinel bit opposite to the lead bit terminates a run that fills the whole body.
  always_comb begin
    ext       = {posit_s1[N-2:0], ~posit_s1[N-2]};
    run_oh_s1 = '0;
    found     = 1'b0;
    for (int j = 1; j <= N - 1; j++) begin
      if (!found && (ext[N-1-j] != ext[N-1])) begin
        run_oh_s1[j-1] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    run_m = '0;
    for (int j = 0; j < N - 1; j++) begin
      if (run_oh_s2[j]) run_m = RW'(j + 1);
    end
    sign      = posit_s2[N-1];
    body_zero = ~|posit_s2[N-2:0];
    // Dropping the run and its terminator left-aligns the remaining exp/frac bits.
    sh_amt    = run_m + RW'(1);
    shifted   = posit_s2 << sh_amt;
    if (posit_s2[N-2] ^ sign) regime = RW'(N - 2) + run_m;
    else                      regime = RW'(N - 1) - run_m;
    eposit_s2 = '0;
    eposit_s2[EW-1-INF_FROM_MSB]  = sign & body_zero;
    eposit_s2[EW-1-ZERO_FROM_MSB] = ~sign & body_zero;
    eposit_s2[EW-1-SIGN_FROM_MSB] = sign;
    if (!body_zero) begin
      eposit_s2[FW +: RW]  = regime;
      eposit_s2[FW-1:0]    = shifted[N-2:2];
    end
  end

endmodule

// File: rtl/decode_posit_pipe.sv
// Two-stage valid/ready pipelined decoder of LANES N-bit posits into eposits.
// Optional NaR/zero output counters are built when DECODE_POSIT_STATS_EN is defined.
module decode_posit_pipe
  import decode_posit_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int LANES = 1,
  localparam int EW    = calc_ew(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*N-1:0]    in_posit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*EW-1:0]   out_eposit
`ifdef DECODE_POSIT_STATS_EN
  ,
  output logic [15:0]           nar_count,
  output logic [15:0]           zero_count
`endif
);

  // Handshake: a beat moves on valid&ready; a valid stage that is not loading holds.
  logic                      load1, load2;
  logic                      v1_q, v1_d, v2_q, v2_d;
  logic [LANES*N-1:0]        posit1_q, posit1_d;
  logic [LANES*(N-1)-1:0]    oh1_q, oh1_d, oh_in;
  logic [LANES*EW-1:0]       ep2_q, ep2_d, ep_next;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    decode_posit_lane #(.N(N)) u_lane (
      .posit_s1  (in_posit[g*N +: N]),
      .run_oh_s1 (oh_in[g*(N-1) +: (N-1)]),
      .posit_s2  (posit1_q[g*N +: N]),
      .run_oh_s2 (oh1_q[g*(N-1) +: (N-1)]),
      .eposit_s2 (ep_next[g*EW +: EW])
    );
  end

  always_comb begin
    load2    = !v2_q || out_ready;
    load1    = !v1_q || load2;
    v1_d     = v1_q;
    posit1_d = posit1_q;
    oh1_d    = oh1_q;
    v2_d     = v2_q;
    ep2_d    = ep2_q;
    if (load1) begin
      v1_d = in_valid;
      if (in_valid) begin
        posit1_d = in_posit;
        oh1_d    = oh_in;
      end
    end
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) ep2_d = ep_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      posit1_q <= '0;
      oh1_q    <= '0;
      ep2_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      posit1_q <= posit1_d;
      oh1_q    <= oh1_d;
      ep2_q    <= ep2_d;
    end
  end

  assign in_ready   = load1;
  assign out_valid  = v2_q;
  assign out_eposit = ep2_q;

`ifdef DECODE_POSIT_STATS_EN
  logic [15:0] nar_q, nar_d, zero_q, zero_d;
  logic [16:0] nar_sum, zero_sum;

  always_comb begin
    nar_sum  = {1'b0, nar_q};
    zero_sum = {1'b0, zero_q};
    if (v2_q && out_ready) begin
      for (int g = 0; g < LANES; g++) begin
        nar_sum  = nar_sum  + 17'(ep2_q[g*EW + EW-1-INF_FROM_MSB]);
        zero_sum = zero_sum + 17'(ep2_q[g*EW + EW-1-ZERO_FROM_MSB]);
      end
    end
    nar_d  = nar_sum[16]  ? 16'hFFFF : nar_sum[15:0];
    zero_d = zero_sum[16] ? 16'hFFFF : zero_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nar_q  <= '0;
      zero_q <= '0;
    end else begin
      nar_q  <= nar_d;
      zero_q <= zero_d;
    end
  end

  assign nar_count  = nar_q;
  assign zero_count = zero_q;
`endif

endmodule

// File: tb/tb_decode_posit_pipe.sv
// Self-checking bench for decode_posit_pipe: N=8 single-lane DUT plus N=16 four-lane DUT,
// scoreboards fed by an arithmetic posit reference model.
module tb_decode_posit_pipe;

  localparam int N   = 8;
  localparam int EW  = 12;
  localparam int NB  = 16;
  localparam int LB  = 4;
  localparam int EWB = 21;
  localparam int FWB = 13;
  localparam int RWB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [N-1:0]  in_posit = '0;
  logic [EW-1:0] out_eposit;

  logic              in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [LB*NB-1:0]  in_posit_b = '0;
  logic [LB*EWB-1:0] out_eposit_b;

`ifdef DECODE_POSIT_STATS_EN
  logic [15:0] nar_count, zero_count, nar_count_b, zero_count_b;
`endif

  decode_posit_pipe #(.N(N), .LANES(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
    .out_valid(out_valid), .out_ready(out_ready), .out_eposit(out_eposit)
`ifdef DECODE_POSIT_STATS_EN
    , .nar_count(nar_count), .zero_count(zero_count)
`endif
  );

  decode_posit_pipe #(.N(NB), .LANES(LB)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_posit(in_posit_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_eposit(out_eposit_b)
`ifdef DECODE_POSIT_STATS_EN
    , .nar_count(nar_count_b), .zero_count(zero_count_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_decode(input int n, input logic [31:0] p);
    int rw, fw, ew, m, k, biased, rem;
    logic s, lead;
    logic [31:0] body, ef, res;
    rw   = $clog2(2 * n - 2);
    fw   = n - 3;
    ew   = 3 + rw + fw;
    s    = p[n-1];
    body = p & ((32'd1 << (n - 1)) - 32'd1);
    if (body == 0) begin
      if (s) res = (32'd1 << (ew - 1)) | (32'd1 << (ew - 3));
      else   res = (32'd1 << (ew - 2));
      return res;
    end
    lead = p[n-2];
    m = 0;
    for (int i = n - 2; i >= 0; i--) begin
      if (p[i] != lead) break;
      m++;
    end
    k      = (lead != s) ? m - 1 : -m;
    biased = k + n - 1;
    rem    = n - 2 - m;
    ef     = 0;
    if (rem > 0) ef = (p & ((32'd1 << rem) - 32'd1)) << (fw - rem);
    res = (32'(s) << (ew - 3)) | (32'(biased) << fw) | ef;
    return res;
  endfunction

  function automatic logic [LB*EWB-1:0] ref_beat_b(input logic [LB*NB-1:0] v);
    logic [LB*EWB-1:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < LB; i++) begin
      t = ref_decode(NB, 32'(v[i*NB +: NB]));
      r[i*EWB +: EWB] = t[EWB-1:0];
    end
    return r;
  endfunction

  // ---------------- scoreboards ----------------
  logic [EW-1:0]     exp_q[$];
  int                acc_q[$];
  logic [LB*EWB-1:0] exp_qb[$];
  int  occ = 0;
  bit  lat_chk = 1'b0;
  bit  hold_pend = 1'b0;
  logic [EW-1:0] hold_val = '0;
  int  out_count = 0, out_count_b = 0;
  int  mnar = 0, mzero = 0, mnar_b = 0, mzero_b = 0;

  always @(negedge clk) begin : mon_a
    logic [31:0]   t;
    logic [EW-1:0] e;
    logic          exp_rdy;
    int            a;
    bit            in_x, out_x;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      occ = 0;
      hold_pend = 1'b0;
      mnar = 0;
      mzero = 0;
    end else begin
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (hold_pend) begin
        checks++;
        if (out_valid !== 1'b1 || out_eposit !== hold_val) begin
          errors++;
          $display("FAIL stable_hold: out_valid=%b out_eposit=%h, required 1 and %h", out_valid, out_eposit, hold_val);
        end
      end
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %b required %b (occupancy %0d out_ready %b)", in_ready, exp_rdy, occ, out_ready);
      end
      if (out_x) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: out_eposit=%h with no beat outstanding", out_eposit);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (out_eposit !== e) begin
            errors++;
            $display("FAIL decode_a: got %h required %h", out_eposit, e);
          end
          if (lat_chk) begin
            checks++;
            if (cyc != a + 2) begin
              errors++;
              $display("FAIL latency: output in cycle %0d, required %0d", cyc, a + 2);
            end
          end
          if (e[EW-1] && mnar < 65535) mnar++;
          if (e[EW-2] && mzero < 65535) mzero++;
        end
        out_count++;
      end
      if (in_x) begin
        t = ref_decode(N, 32'(in_posit));
        exp_q.push_back(t[EW-1:0]);
        acc_q.push_back(cyc);
      end
      occ = occ + int'(in_x) - int'(out_x);
      hold_pend = out_valid && !out_ready;
      hold_val  = out_eposit;
    end
  end

  always @(negedge clk) begin : mon_b
    logic [LB*EWB-1:0] eb;
    if (rst) begin
      exp_qb.delete();
      mnar_b = 0;
      mzero_b = 0;
    end else begin
      if (out_valid_b && out_ready_b) begin
        checks++;
        if (exp_qb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output_b: out_eposit_b=%h", out_eposit_b);
        end else begin
          eb = exp_qb.pop_front();
          if (out_eposit_b !== eb) begin
            errors++;
            $display("FAIL decode_b: got %h required %h", out_eposit_b, eb);
          end
          for (int i = 0; i < LB; i++) begin
            mnar_b  += int'(eb[i*EWB + EWB-1]);
            mzero_b += int'(eb[i*EWB + EWB-2]);
          end
        end
        out_count_b++;
      end
      if (in_valid_b && in_ready_b) exp_qb.push_back(ref_beat_b(in_posit_b));
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_a(input bit v, input logic [N-1:0] p, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_posit  = p;
    out_ready = r;
  endtask

  task automatic drive_b(input bit v, input logic [LB*NB-1:0] p);
    @(posedge clk);
    #1;
    in_valid_b = v;
    in_posit_b = p;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_valid_b = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_eposit !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_a: valid=%b eposit=%h in_ready=%b, required 0 000 1", out_valid, out_eposit, in_ready);
    end
    checks++;
    if (out_valid_b !== 1'b0 || out_eposit_b !== '0 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_b: valid=%b eposit=%h in_ready=%b, required 0 0 1", out_valid_b, out_eposit_b, in_ready_b);
    end
`ifdef DECODE_POSIT_STATS_EN
    checks++;
    if (nar_count !== 16'd0 || zero_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: nar=%0d zero=%0d, required 0 0", nar_count, zero_count);
    end
`endif
  endtask

  task automatic test_basic_decode();
    logic [N-1:0]  bp[5] = '{8'h40, 8'h7F, 8'h01, 8'h53, 8'hC0};
    logic [EW-1:0] be[5] = '{12'h0E0, 12'h1A0, 12'h020, 12'h0F3, 12'h2C0};
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, bp[i], 1'b1);
      drive_a(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      drive_a(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_eposit !== be[i]) begin
        errors++;
        $display("FAIL basic[%0d]: posit %h gave valid=%b eposit=%h, required 1 %h", i, bp[i], out_valid, out_eposit, be[i]);
      end
      drive_a(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_once[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
    lat_chk = 1'b0;
  endtask

  task automatic test_specials();
    logic [N-1:0]  sp[2] = '{8'h00, 8'h80};
    logic [EW-1:0] se[2] = '{12'h400, 12'hA00};
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, sp[i], 1'b1);
      drive_a(1'b0, '0, 1'b1);
      drive_a(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_eposit !== se[i]) begin
        errors++;
        $display("FAIL special[%0d]: posit %h gave valid=%b eposit=%h, required 1 %h", i, sp[i], out_valid, out_eposit, se[i]);
      end
    end
    repeat (3) drive_a(1'b0, '0, 1'b1);
`ifdef DECODE_POSIT_STATS_EN
    @(negedge clk);
    checks++;
    if (nar_count !== 16'd1 || zero_count !== 16'd1) begin
      errors++;
      $display("FAIL special_counters: nar=%0d zero=%0d, required 1 1", nar_count, zero_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n0, acc;
    n0 = out_count;
    acc = 0;
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 8'($urandom), 1'b1);
      @(negedge clk);
      if (in_ready) acc++;
    end
    repeat (4) drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    lat_chk = 1'b0;
    checks++;
    if (acc != 16 || out_count - n0 != 16) begin
      errors++;
      $display("FAIL back_to_back: accepted %0d delivered %0d, required 16 16", acc, out_count - n0);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] bp[4] = '{8'h01, 8'h40, 8'h7F, 8'h53};
    int idx, stall, n0;
    idx = 0;
    stall = 0;
    n0 = out_count;
    for (int c = 0; c < 16; c++) begin
      drive_a(idx < 4, (idx < 4) ? bp[idx] : '0, !(c >= 3 && c <= 6));
      @(negedge clk);
      if (in_valid && !in_ready) stall++;
      if (in_valid && in_ready) idx++;
    end
    checks++;
    if (stall != 4 || idx != 4) begin
      errors++;
      $display("FAIL backpressure_stall: stall cycles %0d accepted %0d, required 4 4", stall, idx);
    end
    checks++;
    if (out_count - n0 != 4) begin
      errors++;
      $display("FAIL backpressure_count: delivered %0d, required 4", out_count - n0);
    end
  endtask

  task automatic test_random();
    int acc, budget, r;
    logic [N-1:0] p;
    acc = 0;
    budget = 0;
    while (acc < 10000 && budget < 45000) begin
      r = $urandom_range(0, 15);
      p = (r == 0) ? 8'h00 : (r == 1) ? 8'h80 : 8'($urandom);
      drive_a(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      budget++;
    end
    repeat (5) drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (acc != 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_stress: accepted %0d outstanding %0d, required 10000 0", acc, exp_q.size());
    end
`ifdef DECODE_POSIT_STATS_EN
    checks++;
    if (int'(nar_count) != mnar || int'(zero_count) != mzero) begin
      errors++;
      $display("FAIL random_counters: nar=%0d zero=%0d, required %0d %0d", nar_count, zero_count, mnar, mzero);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    repeat (3) drive_a(1'b1, 8'($urandom), 1'b0);
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_eposit !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_inflight: valid=%b eposit=%h in_ready=%b, required 0 000 1", out_valid, out_eposit, in_ready);
    end
`ifdef DECODE_POSIT_STATS_EN
    checks++;
    if (nar_count !== 16'd0 || zero_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_inflight_counters: nar=%0d zero=%0d, required 0 0", nar_count, zero_count);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ghost[%0d]: out_valid=%b after reset, required 0", i, out_valid);
      end
    end
    drive_a(1'b1, 8'h40, 1'b1);
    drive_a(1'b0, '0, 1'b1);
    drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_eposit !== 12'h0E0) begin
      errors++;
      $display("FAIL reset_restart: valid=%b eposit=%h, required 1 0e0", out_valid, out_eposit);
    end
    drive_a(1'b0, '0, 1'b1);
  endtask

  task automatic test_multilane();
    logic [LB*NB-1:0] beat;
    bit got;
    int n0;
    beat = {16'h7FFF, 16'h4000, 16'h8000, 16'h0000};
    got = 1'b0;
    drive_b(1'b1, beat);
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b0, '0);
      @(negedge clk);
      if (out_valid_b) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL multilane_timeout: out_valid_b=%b after 8 cycles, required 1", out_valid_b);
    end else begin
      checks++;
      if (out_eposit_b[EWB-2] !== 1'b1 || out_eposit_b[EWB + EWB-1] !== 1'b1 ||
          out_eposit_b[2*EWB + FWB +: RWB] !== 5'd15 || out_eposit_b[3*EWB + FWB +: RWB] !== 5'd29) begin
        errors++;
        $display("FAIL multilane_fields: got %h, required zero/NaR flags and regimes 15, 29", out_eposit_b);
      end
    end
    repeat (3) drive_b(1'b0, '0);
`ifdef DECODE_POSIT_STATS_EN
    @(negedge clk);
    checks++;
    if (nar_count_b !== 16'd1 || zero_count_b !== 16'd1) begin
      errors++;
      $display("FAIL multilane_counters: nar=%0d zero=%0d, required 1 1", nar_count_b, zero_count_b);
    end
`endif
    n0 = out_count_b;
    for (int i = 0; i < 40; i++) begin
      drive_b(1'b1, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
    end
    repeat (4) drive_b(1'b0, '0);
    @(negedge clk);
    checks++;
    if (out_count_b - n0 != 40 || exp_qb.size() != 0) begin
      errors++;
      $display("FAIL multilane_stream: delivered %0d outstanding %0d, required 40 0", out_count_b - n0, exp_qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_multilane();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
